// File: rtl/mem_fu_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle memory FU among NREQ requesters.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_fu_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_mem_w,
  input  logic [3*NREQ-1:0]    req_bhw,
  input  logic [32*NREQ-1:0]   req_rs1,
  input  logic [32*NREQ-1:0]   req_rs2,
  input  logic [32*NREQ-1:0]   req_imm,
  output logic [NREQ-1:0]      done,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic                 fu_en,
  output logic                 fu_mem_w,
  output logic [2:0]           fu_bhw,
  output logic [31:0]          fu_rs1,
  output logic [31:0]          fu_rs2,
  output logic [31:0]          fu_imm,
  input  logic [31:0]          fu_mem_data,
  input  logic                 fu_finish
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]          perf_grants,
  output logic [31:0]          perf_stall
`endif
);

  localparam int RW = 2**PTR_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  ptr, grant, pick, idx;
  logic              pick_vld;
  logic [RW-1:0]     req_x;
  logic [NREQ-1:0]   grant_oh;
  int                j;
  logic              sel_mem_w;
  logic [2:0]        sel_bhw;
  logic [31:0]       sel_rs1, sel_rs2, sel_imm;

  assign req_x = RW'(req);

  // Search from ptr upward with wrap; iterating downward lets the nearest hit win.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    j        = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = PTR_W'(j);
      if (req_x[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_mem_w = 1'b0;
    sel_bhw   = '0;
    sel_rs1   = '0;
    sel_rs2   = '0;
    sel_imm   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == PTR_W'(i)) begin
        sel_mem_w = req_mem_w[i];
        sel_bhw   = req_bhw[3*i +: 3];
        sel_rs1   = req_rs1[32*i +: 32];
        sel_rs2   = req_rs2[32*i +: 32];
        sel_imm   = req_imm[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_vld) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (fu_finish) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= '0;
      grant <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && pick_vld) grant <= pick;
      if (state == S_RESP)
        ptr <= (grant == PTR_W'(NREQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  // Operands are captured once at grant and held until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_mem_w <= 1'b0;
      fu_bhw   <= '0;
      fu_rs1   <= '0;
      fu_rs2   <= '0;
      fu_imm   <= '0;
      rdata    <= '0;
    end else begin
      if (state == S_IDLE && pick_vld) begin
        fu_mem_w <= sel_mem_w;
        fu_bhw   <= sel_bhw;
        fu_rs1   <= sel_rs1;
        fu_rs2   <= sel_rs2;
        fu_imm   <= sel_imm;
      end
      if (state == S_WAIT && fu_finish)
        rdata <= fu_mem_w ? 32'h0 : fu_mem_data;
    end
  end

  assign grant_oh = NREQ'(1) << grant;
  assign done     = (state == S_RESP) ? grant_oh : '0;
  assign fu_en    = (state == S_ISSUE);
  assign busy     = (state != S_IDLE);

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grants <= '0;
      perf_stall  <= '0;
    end else begin
      if (state == S_IDLE && pick_vld) perf_grants <= perf_grants + 32'd1;
      if (busy && |(req & ~grant_oh)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
